// File: rtl/alu4_nibble_seq.sv
// -----------------------------------------------------------------------------
// alu4_nibble_seq
//
// Multi-cycle controller that runs a W = 4*NIBBLES bit operation through one
// external, purely combinational 4-bit ALU. It presents one nibble per cycle,
// least significant first, and chains the ALU carry between nibbles. It then
// assembles the wide result and produces the wide co/V/Z flags.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    operation request, sampled only in IDLE
//   M, S, cin                mode, function select, operation carry-in
//   a, b        [W-1:0]      wide operands, latched on acceptance
//   busy                     high during the RUN cycles
//   done                     one-cycle pulse; result/flags valid from here on
//   result      [W-1:0]      assembled result, held until the next start
//   co, V, Z                 wide flags (co/V forced to 0 in logic mode)
//   alu_a, alu_b, alu_cin,
//   alu_M, alu_S             nibble drive to the ALU4 (all 0 outside RUN)
//   alu_do, alu_co, alu_V,
//   alu_Z                    ALU4 response (alu_Z unused; wide Z is local)
// -----------------------------------------------------------------------------
module alu4_nibble_seq #(
  parameter int NIBBLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   M,
  input  logic [3:0]             S,
  input  logic                   cin,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   co,
  output logic                   V,
  output logic                   Z,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic                   alu_M,
  output logic [3:0]             alu_S,
  input  logic [3:0]             alu_do,
  input  logic                   alu_co,
  input  logic                   alu_V,
  input  logic                   alu_Z
);

  localparam int W  = 4 * NIBBLES;
  // One extra bit so the index can reach NIBBLES without wrapping.
  localparam int IW = $clog2(NIBBLES) + 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            m_q, m_d;
  logic [3:0]      s_q, s_d;
  logic            cin_q, cin_d;
  logic [W-1:0]    result_q, result_d;
  logic            co_q, co_d;
  logic            v_q, v_d;
  logic            z_q, z_d;

  // Bit offset of the current nibble (idx * 4).
  logic [IW+1:0]   sh;
  assign sh = {idx_q, 2'b00};

  // The wide zero flag is computed locally from the assembled result.
  logic unused_alu_z;
  assign unused_alu_z = alu_Z;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    s_d      = s_q;
    cin_d    = cin_q;
    result_d = result_q;
    co_d     = co_q;
    v_d      = v_q;
    z_d      = z_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    alu_M    = 1'b0;
    alu_S    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          a_d      = a;
          b_d      = b;
          m_d      = M;
          s_d      = S;
          cin_d    = cin;
          idx_d    = '0;
          result_d = '0;
        end
      end

      ST_RUN: begin
        alu_a   = 4'(a_q >> sh);
        alu_b   = 4'(b_q >> sh);
        alu_M   = m_q;
        alu_S   = s_q;
        // Arithmetic chains the nibble carry; logic mode passes cin to every nibble.
        alu_cin = (idx_q == '0) ? cin_q : (m_q ? carry_q : cin_q);

        result_d = (result_q & ~(W'(4'hF) << sh)) | (W'(alu_do) << sh);
        carry_d  = alu_co;
        idx_d    = idx_q + IW'(1);

        if (idx_q == LAST) begin
          state_d = ST_DONE;
          co_d    = m_q & alu_co;
          v_d     = m_q & alu_V;
          z_d     = (result_d == '0);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them
    // update together from values sampled before the edge.
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= 1'b0;
      s_q      <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      s_q      <= s_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      co_q     <= co_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign co     = co_q;
  assign V      = v_q;
  assign Z      = z_q;

endmodule

// File: doc/alu4_nibble_seq.md
Name: alu4_nibble_seq

Overview:
Multi-cycle controller that drives a single 4-bit ALU4 instance nibble-serially to execute operations of width 4*NIBBLES bits.
- Latches wide operands on a start handshake, then presents one nibble per cycle to the ALU, least significant first.
- Chains the ALU carry-out between nibbles, assembles the wide result, and produces wide co/V/Z flags.
- Sits between the register/operand logic and the ALU4 datapath; the ALU4 itself stays purely combinational.

Parameters:
NIBBLES, 2, number of 4-bit slices per operation (operand width W = 4*NIBBLES); legal range 1..8

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
M  input  1  mode: 0 = logic, 1 = arithmetic (passed to ALU)
S  input  4  ALU function select (1001 add, 0110 sub when M=1)
cin  input  1  operation carry-in (add 0, sub 1, logic don't-care/passed)
a  input  W  operand A
b  input  W  operand B
busy  output  1  high while an operation is in RUN
done  output  1  one-cycle pulse; result/flags valid from this cycle
result  output  W  assembled result; held until next accepted start
co  output  1  carry-out of top nibble (arith); 0 in logic mode
V  output  1  ALU V from top nibble (arith); 0 in logic mode
Z  output  1  1 when result == 0 (both modes)
alu_a  output  4  nibble of A to ALU4
alu_b  output  4  nibble of B to ALU4
alu_cin  output  1  carry-in to ALU4
alu_M  output  1  mode to ALU4
alu_S  output  4  select to ALU4
alu_do  input  4  ALU4 data out
alu_co  input  1  ALU4 carry out
alu_V  input  1  ALU4 overflow
alu_Z  input  1  ALU4 zero (unused; wide Z computed locally)

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst). On reset: state IDLE, busy=0, done=0, result=0, co=0, V=0, Z=0, nibble index=0, carry register=0, latched operands/controls=0.
- States:
  - IDLE -> RUN on start=1. Same edge latches a, b, M, S, cin and clears index and result.
  - RUN: index k = 0..NIBBLES-1. Each cycle:
    - drive alu_a=a_q[4k+3:4k], alu_b=b_q[4k+3:4k], alu_M=M_q, alu_S=S_q.
    - alu_cin = cin_q when k=0; otherwise carry_q if M_q=1, cin_q if M_q=0.
    - on the edge: result[4k+3:4k] <= alu_do, carry_q <= alu_co, k <= k+1.
    - leave RUN after the k=NIBBLES-1 edge. On that edge: co <= M_q ? alu_co : 0, V <= M_q ? alu_V : 0, Z <= (assembled result == 0).
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge 0; done high in the cycle after edge NIBBLES (NIBBLES+1 cycles start-to-done). busy=1 exactly during RUN cycles.
- Outside RUN, the ALU drive outputs are all 0.
- start while busy or in DONE is ignored (no queueing). Operand changes after acceptance have no effect.
- result/co/V/Z hold their values from DONE until the next accepted start, which clears result only.
- Any M=1 select is chained as arithmetic. co is the raw ALU carry: for subtract, co=1 means no borrow.
- Reset in any state wins over all other activity; the in-flight operation is discarded and no done is issued.
- Index counter is sized clog2(NIBBLES)+1 and never wraps within an operation.

Test Plan:
1. NIBBLES=2, M=1 S=1001 cin=0 a=0x7F b=0x01, start 1 cycle -> busy 2 cycles, done 3rd cycle, result=0x80 co=0 V=1 Z=0.
2. Add a=0xFF b=0x01 -> result=0x00 co=1 V=0 Z=1; check alu_cin=1 during second RUN cycle.
3. Sub M=1 S=0110 cin=1: a=0x50 b=0x30 -> 0x20 co=1 V=0; a=0x80 b=0x01 -> 0x7F V=1 co=1.
4. Logic M=0 S=0110 cin=1 a=0xCA b=0x5C -> result=0x96 co=0 V=0 Z=0; S=0000 -> 0x00 Z=1; S=1111 -> 0xFF.
5. Start held high through busy with changing a/b -> exactly one operation, result from first-sampled operands. Assert rst during RUN cycle 1 -> next cycle all outputs 0, no done; following add 0x12+0x34 -> 0x46.
6. NIBBLES=4, add a=0x0FFF b=0x0001 cin=0 -> busy 4 cycles, result=0x1000 co=0 V=0.
